cpu_run_host: RTL and testbench

Host-side sequencer for the CPU's Reset/Start/Ack run handshake: the initiating end of the protocol the CPU responds to. On a `Go` request it resets the CPU once, then issues one `CpuStart` pulse per program, waits for `Ack`, and measures per-program run length in cycles. It sits in the top-level harness between the test controller and the CPU, driving the CPU's `Reset` and `Start` ports and observing its `Ack` port.

---
 rtl/cpu_run_host.sv | 160 ++++++++++++++++
 tb/tb_cpu_run_host.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_host.sv
// Host-side run sequencer: resets the CPU once per batch, then starts each program and times it.
// Optional watchdog enabled by defining HOST_TIMEOUT_EN.
module cpu_run_host #(
    parameter int unsigned W              = 16,
    parameter int unsigned NPROG_W        = 2,
    parameter int unsigned RST_CYCLES     = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Go,
    input  logic [NPROG_W-1:0] NumProgs,
    input  logic               Ack,
    output logic               CpuReset,
    output logic               CpuStart,
    output logic               Busy,
    output logic               Done,
    output logic [NPROG_W-1:0] ProgIdx,
    output logic [W-1:0]       RunCycles,
    output logic               RunValid,
    output logic               Timeout
);

    typedef enum logic [2:0] {StIdle, StRst, StStart, StWait, StDone} state_e;

    localparam logic [W-1:0] RstLoad = W'(RST_CYCLES);

    state_e             r_state, w_state_d;
    logic [W-1:0]       r_cnt, w_cnt_d;
    logic [NPROG_W-1:0] r_nprog, w_nprog_d;
    logic [NPROG_W-1:0] r_prog_idx, w_prog_idx_d;
    logic               r_cpu_reset, w_cpu_reset_d;
    logic               r_cpu_start, w_cpu_start_d;
    logic               r_busy, w_busy_d;
    logic               r_done, w_done_d;
    logic [W-1:0]       r_run_cycles, w_run_cycles_d;
    logic               r_run_valid, w_run_valid_d;

`ifdef HOST_TIMEOUT_EN
    localparam logic [W-1:0] TimeoutVal = W'(TIMEOUT_CYCLES);
    logic r_timeout, w_timeout_d;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_nprog_d      = r_nprog;
        w_prog_idx_d   = r_prog_idx;
        w_cpu_reset_d  = r_cpu_reset;
        w_cpu_start_d  = 1'b0;
        w_run_cycles_d = r_run_cycles;
        w_run_valid_d  = 1'b0;
`ifdef HOST_TIMEOUT_EN
        w_timeout_d    = r_timeout;
`endif
        unique case (r_state)
            StIdle, StDone: begin
                if (Go) begin
                    w_nprog_d     = NumProgs;
                    w_prog_idx_d  = '0;
                    w_cnt_d       = RstLoad;
                    w_cpu_reset_d = 1'b1;
                    w_state_d     = StRst;
`ifdef HOST_TIMEOUT_EN
                    w_timeout_d   = 1'b0;
`endif
                end
            end
            StRst: begin
                w_cnt_d = r_cnt - W'(1);
                // Counter holds 1 on the last reset cycle
                if (r_cnt <= W'(1)) begin
                    w_cpu_reset_d = 1'b0;
                    w_cpu_start_d = 1'b1;
                    w_state_d     = StStart;
                end
            end
            StStart: begin
                w_cnt_d   = '0;
                w_state_d = StWait;
            end
            StWait: begin
                if (Ack) begin
                    w_run_cycles_d = r_cnt;
                    w_run_valid_d  = 1'b1;
                    if (r_prog_idx == r_nprog) begin
                        w_state_d = StDone;
                    end else begin
                        w_prog_idx_d  = r_prog_idx + NPROG_W'(1);
                        w_cpu_start_d = 1'b1;
                        w_state_d     = StStart;
                    end
`ifdef HOST_TIMEOUT_EN
                end else if (r_cnt == TimeoutVal) begin
                    // Hold the CPU in reset so a runaway program stops
                    w_timeout_d    = 1'b1;
                    w_run_cycles_d = TimeoutVal;
                    w_run_valid_d  = 1'b1;
                    w_cpu_reset_d  = 1'b1;
                    w_state_d      = StDone;
`endif
                end else if (r_cnt != '1) begin
                    w_cnt_d = r_cnt + W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
        w_busy_d = (w_state_d == StRst) || (w_state_d == StStart) || (w_state_d == StWait);
        w_done_d = (w_state_d == StDone);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_nprog      <= '0;
            r_prog_idx   <= '0;
            r_cpu_reset  <= 1'b0;
            r_cpu_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_run_cycles <= '0;
            r_run_valid  <= 1'b0;
`ifdef HOST_TIMEOUT_EN
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_nprog      <= w_nprog_d;
            r_prog_idx   <= w_prog_idx_d;
            r_cpu_reset  <= w_cpu_reset_d;
            r_cpu_start  <= w_cpu_start_d;
            r_busy       <= w_busy_d;
            r_done       <= w_done_d;
            r_run_cycles <= w_run_cycles_d;
            r_run_valid  <= w_run_valid_d;
`ifdef HOST_TIMEOUT_EN
            r_timeout    <= w_timeout_d;
`endif
        end
    end

    assign CpuReset  = r_cpu_reset;
    assign CpuStart  = r_cpu_start;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign ProgIdx   = r_prog_idx;
    assign RunCycles = r_run_cycles;
    assign RunValid  = r_run_valid;
`ifdef HOST_TIMEOUT_EN
    assign Timeout   = r_timeout;
`else
    assign Timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_host.sv
// Scoreboard bench for cpu_run_host: stimulus queues expected run results, a monitor checks
// them whenever RunValid pulses. Covers the watchdog path when HOST_TIMEOUT_EN is defined.
module tb_cpu_run_host;

    localparam int unsigned W          = 4;
    localparam int unsigned NPROG_W    = 2;
    localparam int unsigned RST_CYCLES = 2;
    localparam logic [15:0] TMO        = 16'd10;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b1;
    logic               Go = 1'b0;
    logic [NPROG_W-1:0] NumProgs = '0;
    logic               Ack = 1'b0;
    logic               CpuReset, CpuStart, Busy, Done, RunValid, Timeout;
    logic [NPROG_W-1:0] ProgIdx;
    logic [W-1:0]       RunCycles;

    typedef struct packed {
        logic [W-1:0] cyc;
        logic         done;
        logic         tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rst_seen = 0;
    int   start_seen = 0;

    cpu_run_host #(
        .W              (W),
        .NPROG_W        (NPROG_W),
        .RST_CYCLES     (RST_CYCLES),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Go        (Go),
        .NumProgs  (NumProgs),
        .Ack       (Ack),
        .CpuReset  (CpuReset),
        .CpuStart  (CpuStart),
        .Busy      (Busy),
        .Done      (Done),
        .ProgIdx   (ProgIdx),
        .RunCycles (RunCycles),
        .RunValid  (RunValid),
        .Timeout   (Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: counts reset/start cycles and scores every RunValid pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (CpuReset) rst_seen++;
            if (CpuStart) start_seen++;
            if (RunValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_runvalid: got RunCycles %0d, expected no result",
                             RunCycles);
                end else begin
                    e = exp_q.pop_front();
                    check("run_cycles", 32'(RunCycles), 32'(e.cyc));
                    check("done_at_runvalid", 32'(Done), 32'(e.done));
                    check("timeout_at_runvalid", 32'(Timeout), 32'(e.tmo));
                end
            end
        end
    end

    task automatic start_batch(input logic [NPROG_W-1:0] np, output int rb, output int sb);
        @(negedge Clk);
        rb = rst_seen;
        sb = start_seen;
        NumProgs = np;
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        NumProgs = ~np;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge Clk);
            ok = CpuStart;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL start_wait: got no CpuStart within 20 cycles, expected a pulse");
        end
    endtask

    // Ack after n WAIT cycles; hold_start keeps Ack high across the START cycle
    task automatic run_prog(input int k, input int n, input bit last, input bit hold_start,
                            input bit go_mid);
        bit   ok;
        exp_t e;
        wait_start(ok);
        if (!ok) return;
        check("prog_idx", 32'(ProgIdx), 32'(k));
        Ack = hold_start;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Ack = 1'b0;
            Go  = go_mid && (i == 1);
        end
        @(negedge Clk);
        Ack = 1'b1;
        Go  = 1'b0;
        e.cyc  = (n > 15) ? 4'hF : W'(n);
        e.done = last;
        e.tmo  = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic finish_batch(input int rb, input int sb, input int starts);
        @(negedge Clk);
        Ack = 1'b0;
        check("done", 32'(Done), 32'd1);
        check("busy_after_done", 32'(Busy), 32'd0);
        check("reset_phases", 32'(rst_seen - rb), 32'(RST_CYCLES));
        check("start_pulses", 32'(start_seen - sb), 32'(starts));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected end of run");
        $fatal(1, "bench time limit");
    end

    initial begin
        int rb, sb;
        bit ok;
        #1 Reset_n = 1'b0;
        #1;
        check("reset_outputs",
              32'({CpuReset, CpuStart, Busy, Done, ProgIdx, RunCycles, RunValid, Timeout}), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        // Single program, 5 wait cycles
        start_batch(2'd0, rb, sb);
        check("busy_in_reset", 32'(Busy), 32'd1);
        check("cpu_reset_high", 32'(CpuReset), 32'd1);
        run_prog(0, 5, 1'b1, 1'b0, 1'b0);
        finish_batch(rb, sb, 1);

        // Three programs: 3, 0, 7
        start_batch(2'd2, rb, sb);
        run_prog(0, 3, 1'b0, 1'b0, 1'b0);
        run_prog(1, 0, 1'b0, 1'b0, 1'b0);
        run_prog(2, 7, 1'b1, 1'b0, 1'b0);
        finish_batch(rb, sb, 3);
        check("prog_idx_last", 32'(ProgIdx), 32'd2);

        // Go pulse during WAIT ignored; Ack held across START not counted
        start_batch(2'd1, rb, sb);
        run_prog(0, 3, 1'b0, 1'b0, 1'b1);
        run_prog(1, 4, 1'b1, 1'b1, 1'b0);
        finish_batch(rb, sb, 2);

        // Asynchronous reset in the middle of WAIT
        start_batch(2'd0, rb, sb);
        wait_start(ok);
        Ack = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("midrun_reset_outputs",
              32'({CpuReset, CpuStart, Busy, Done, ProgIdx, RunCycles, RunValid, Timeout}), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        start_batch(2'd0, rb, sb);
        run_prog(0, 2, 1'b1, 1'b0, 1'b0);
        finish_batch(rb, sb, 1);

`ifdef HOST_TIMEOUT_EN
        begin
            exp_t e;
            bit   done_seen;
            start_batch(2'd1, rb, sb);
            wait_start(ok);
            Ack = 1'b0;
            e.cyc  = W'(TMO);
            e.done = 1'b1;
            e.tmo  = 1'b1;
            exp_q.push_back(e);
            done_seen = 1'b0;
            for (int i = 0; i < 30 && !done_seen; i++) begin
                @(negedge Clk);
                done_seen = Done;
            end
            check("timeout_reaches_done", 32'(done_seen), 32'd1);
            repeat (3) @(negedge Clk);
            check("timeout_flag", 32'(Timeout), 32'd1);
            check("timeout_cpu_reset", 32'(CpuReset), 32'd1);
            check("timeout_prog_idx", 32'(ProgIdx), 32'd0);
            check("timeout_single_start", 32'(start_seen - sb), 32'd1);
            start_batch(2'd0, rb, sb);
            check("timeout_cleared", 32'(Timeout), 32'd0);
            run_prog(0, 1, 1'b1, 1'b0, 1'b0);
            @(negedge Clk);
            Ack = 1'b0;
            check("done_after_timeout", 32'(Done), 32'd1);
        end
`else
        // W=4: 20 wait cycles saturate at 15
        start_batch(2'd0, rb, sb);
        run_prog(0, 20, 1'b1, 1'b0, 1'b0);
        finish_batch(rb, sb, 1);
        check("timeout_tied_low", 32'(Timeout), 32'd0);
`endif

        repeat (3) @(negedge Clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
